// File: rtl/wb_write_queue.sv
// Register-file write queue: merges normal and link writebacks, drains one write per cycle
// and offers a youngest-match bypass lookup. Define WB_TRACE_EN to print each committed write.
module wb_write_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_valid,
    input  logic [4:0]  wr_reg,
    input  logic [31:0] wr_data,
    input  logic        link_valid,
    input  logic [4:0]  link_reg,
    input  logic [31:0] link_pc,
    input  logic [31:0] in_pc,
    output logic        in_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] rf_pc,
    input  logic [4:0]  rd_reg1,
    input  logic [4:0]  rd_reg2,
    output logic        byp_hit1,
    output logic [31:0] byp_data1,
    output logic        byp_hit2,
    output logic [31:0] byp_data2,
    output logic        busy
);

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
        logic [31:0] pc;
    } entry_t;

    localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);
    localparam logic [AW:0] TwoCnt   = (AW+1)'(2);

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    entry_t        ent_wr, ent_lk, head_ent;
    logic          take_wr, take_lk, deq;
    logic [AW:0]   enq_n;
    logic [AW-1:0] lk_ptr;

    // Room for a dual request is required, so acceptance never depends on the same-cycle drain.
    assign in_ready = (DepthCnt - count_q) >= TwoCnt;
    assign deq      = (count_q != '0);
    assign busy     = deq;

    always_comb begin
        ent_wr  = '{r: wr_reg, d: wr_data, pc: in_pc};
        ent_lk  = '{r: link_reg, d: link_pc + 32'd8, pc: in_pc};
        take_wr = in_ready & wr_valid & (wr_reg != 5'd0);
        take_lk = in_ready & link_valid & (link_reg != 5'd0);
        enq_n   = (AW+1)'(take_wr) + (AW+1)'(take_lk);
        lk_ptr  = take_wr ? tail_q + AW'(1) : tail_q;

        mem_d = mem_q;
        if (take_wr) begin
            mem_d[tail_q] = ent_wr;
        end
        if (take_lk) begin
            mem_d[lk_ptr] = ent_lk;
        end

        tail_d  = tail_q + enq_n[AW-1:0];
        head_d  = head_q + AW'(deq);
        count_d = count_q + enq_n - (AW+1)'(deq);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Outputs are forced to zero when empty so stale slots never leak out.
    always_comb begin
        head_ent = mem_q[head_q];
        rf_we    = deq;
        rf_waddr = deq ? head_ent.r  : 5'd0;
        rf_wdata = deq ? head_ent.d  : 32'd0;
        rf_pc    = deq ? head_ent.pc : 32'd0;
    end

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        logic [AW-1:0] idx;
        logic          live;
        idx       = '0;
        live      = 1'b0;
        byp_hit1  = 1'b0;
        byp_data1 = 32'd0;
        byp_hit2  = 1'b0;
        byp_data2 = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            idx  = head_q + AW'(i);
            live = (AW+1)'(i) < count_q;
            if (live && rd_reg1 != 5'd0 && mem_q[idx].r == rd_reg1) begin
                byp_hit1  = 1'b1;
                byp_data1 = mem_q[idx].d;
            end
            if (live && rd_reg2 != 5'd0 && mem_q[idx].r == rd_reg2) begin
                byp_hit2  = 1'b1;
                byp_data2 = mem_q[idx].d;
            end
        end
    end

`ifdef WB_TRACE_EN
    always @(posedge clock) begin
        if (!reset && rf_we) begin
            $display("@%h: $%0d <= %h", rf_pc, rf_waddr, rf_wdata);
        end
    end
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: a queue-level reference model predicts acceptance,
// occupancy and bypass results; a negedge monitor checks every register-file write in order.
module tb_wb_write_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
        logic [31:0] pc;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0, link_valid = 1'b0;
    logic [4:0]  wr_reg = '0, link_reg = '0, rd_reg1 = '0, rd_reg2 = '0;
    logic [31:0] wr_data = '0, link_pc = '0, in_pc = '0;
    logic        in_ready, rf_we, byp_hit1, byp_hit2, busy;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, rf_pc, byp_data1, byp_data2;

    wb_write_queue #(.DEPTH(DEPTH), .AW(2)) dut (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_reg(wr_reg), .wr_data(wr_data),
        .link_valid(link_valid), .link_reg(link_reg), .link_pc(link_pc), .in_pc(in_pc),
        .in_ready(in_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_pc(rf_pc), .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
        .byp_hit1(byp_hit1), .byp_data1(byp_data1), .byp_hit2(byp_hit2),
        .byp_data2(byp_data2), .busy(busy)
    );

    always #5 clock = ~clock;

    ent_t pend[$];   // model of what the queue holds right now
    ent_t exp_q[$];  // expected register-file writes, oldest first
    int   n_chk = 0, n_pass = 0, n_writes = 0, n_pushed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic byp_model(input logic [4:0] r, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = 32'd0;
        foreach (pend[i]) begin
            if (r != 5'd0 && pend[i].r == r) begin
                hit = 1'b1;
                d   = pend[i].d;
            end
        end
    endtask

    // Monitor: every write the DUT presents must be the oldest expected one.
    ent_t m_e;
    always @(negedge clock) begin
        if (rf_we === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_write: got $%0d <= %h expected no write (t=%0t)",
                         rf_waddr, rf_wdata, $time);
            end else begin
                m_e = exp_q.pop_front();
                chk("rf_waddr", 32'(rf_waddr), 32'(m_e.r));
                chk("rf_wdata", rf_wdata, m_e.d);
                chk("rf_pc", rf_pc, m_e.pc);
            end
        end
    end

    // One clock cycle: drive a request, check state-dependent outputs, advance the model.
    task automatic cycle(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                         input logic lv, input logic [4:0] lr, input logic [31:0] lpc,
                         input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                         output bit acc);
        logic        rdy, h;
        logic [31:0] d;
        ent_t        e;
        @(posedge clock);
        #1;
        wr_valid = wv; wr_reg = wr; wr_data = wd;
        link_valid = lv; link_reg = lr; link_pc = lpc;
        in_pc = pc; rd_reg1 = r1; rd_reg2 = r2;
        #2;
        rdy = (DEPTH - pend.size()) >= 2;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("busy", 32'(busy), 32'(pend.size() != 0));
        chk("rf_we", 32'(rf_we), 32'(pend.size() != 0));
        byp_model(r1, h, d);
        chk("byp_hit1", 32'(byp_hit1), 32'(h));
        chk("byp_data1", byp_data1, d);
        byp_model(r2, h, d);
        chk("byp_hit2", 32'(byp_hit2), 32'(h));
        chk("byp_data2", byp_data2, d);
        if (pend.size() != 0) void'(pend.pop_front());
        if (rdy && wv && wr != 5'd0) begin
            e = '{r: wr, d: wd, pc: pc};
            pend.push_back(e); exp_q.push_back(e); n_pushed++;
        end
        if (rdy && lv && lr != 5'd0) begin
            e = '{r: lr, d: lpc + 32'd8, pc: pc};
            pend.push_back(e); exp_q.push_back(e); n_pushed++;
        end
        acc = rdy;
    endtask

    task automatic idle(input int n, input logic [4:0] r1, input logic [4:0] r2);
        bit a;
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, r1, r2, a);
    endtask

    initial begin
        bit acc;
        int sent;
        #2;
        chk("rst_rf_we", 32'(rf_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_rf_wdata", rf_wdata, 0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Single write appears on the next cycle for exactly one cycle.
        cycle(1, 5, 32'h1234, 0, 0, 0, 32'h3000, 5, 0, acc);
        idle(3, 5, 0);

        // Dual write to $31: link is younger and wins the bypass.
        cycle(1, 31, 32'hAA, 1, 31, 32'h3010, 32'h3010, 31, 0, acc);
        cycle(0, 0, 0, 0, 0, 0, 0, 31, 0, acc);
        chk("dual_byp_data1", byp_data1, 32'h3018);
        idle(3, 31, 9);

        // $0 filter, PC+8 wrap, bypass miss on $9 and on $0.
        cycle(1, 0, 32'hFF, 0, 0, 0, 32'h4000, 0, 0, acc);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 9, acc);
        chk("zero_busy", 32'(busy), 0);
        chk("miss_byp_hit2", 32'(byp_hit2), 0);
        chk("miss_byp_data2", byp_data2, 0);
        cycle(1, 0, 32'hFF, 1, 7, 32'hFFFFFFFC, 32'hFFFFFFFC, 7, 0, acc);
        cycle(0, 0, 0, 0, 0, 0, 0, 7, 0, acc);
        chk("wrap_rf_wdata", rf_wdata, 32'h4);
        idle(3, 0, 9);

        // Full stall: dual requests every cycle, held until accepted.
        sent = 0;
        for (int k = 0; k < 40 && sent < 10; k++) begin
            cycle(1, 5'(sent + 1), 32'h100 + sent, 1, 5'(sent + 2), 32'h5000 + 32'(sent * 4),
                  32'h6000 + 32'(sent), 5'(sent + 1), 5'(sent + 2), acc);
            if (acc) sent += 2;
        end
        chk("stall_sent", sent, 10);
        idle(6, 1, 10);

        // Reset mid-drain discards everything.
        cycle(1, 3, 32'h33, 1, 4, 32'h7000, 32'h7000, 3, 4, acc);
        cycle(1, 6, 32'h66, 0, 0, 0, 32'h7004, 3, 6, acc);
        @(posedge clock);
        #1;
        wr_valid = 0; link_valid = 0;
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_rf_we", 32'(rf_we), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        chk("mid_rst_byp_hit1", 32'(byp_hit1), 0);
        chk("mid_rst_rf_waddr", 32'(rf_waddr), 0);
        n_pushed -= exp_q.size();
        pend.delete();
        exp_q.delete();
        @(negedge clock);
        #2 reset = 1'b0;
        idle(4, 3, 6);

        // Random traffic with small register range to provoke collisions and $0.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                  $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), acc);
        end
        idle(8, 1, 2);

        chk("sb_empty", exp_q.size(), 0);
        chk("write_count", n_writes, n_pushed);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
